// File: rtl/dmac_ctrl_slave.sv
// AXI4-Lite control responder for the DMA engine: holds transfer configuration,
// issues a one-cycle start pulse and reports busy/done status to the host.
module dmac_ctrl_slave #(
    parameter int unsigned C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int unsigned C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst,
    input  logic                                    s_axi_control_awvalid,
    output logic                                    s_axi_control_awready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                                    s_axi_control_wvalid,
    output logic                                    s_axi_control_wready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                                    s_axi_control_bvalid,
    input  logic                                    s_axi_control_bready,
    output logic [1:0]                              s_axi_control_bresp,
    input  logic                                    s_axi_control_arvalid,
    output logic                                    s_axi_control_arready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                                    s_axi_control_rvalid,
    input  logic                                    s_axi_control_rready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                              s_axi_control_rresp,
    output logic                                    ap_start,
    input  logic                                    ap_done,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   byte_len,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   src_addr,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   dst_addr
);

    localparam int unsigned AW = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_CONTROL_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;

    localparam logic [AW-1:0] ADDR_CTRL = AW'(32'h010);
    localparam logic [AW-1:0] ADDR_LEN  = AW'(32'h014);
    localparam logic [AW-1:0] ADDR_SRC  = AW'(32'h018);
    localparam logic [AW-1:0] ADDR_DST  = AW'(32'h01C);

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    wstate_e w_state_q, w_state_d;
    rstate_e r_state_q, r_state_d;

    logic          awready_q, awready_d;
    logic          wready_q,  wready_d;
    logic          bvalid_q,  bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q,  rvalid_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [AW-1:0] waddr_q,   waddr_d;
    logic          ap_start_q, ap_start_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [DW-1:0] byte_len_q, byte_len_d;
    logic [DW-1:0] src_q,     src_d;
    logic [DW-1:0] dst_q,     dst_d;

    logic          aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic          start_acc_c, cfg_we_c, ctrl_rd_c;
    logic [DW-1:0] ctrl_status_c, rdata_sel_c;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < int'(SW); i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign aw_hs_c = s_axi_control_awvalid & awready_q;
    assign w_hs_c  = s_axi_control_wvalid  & wready_q;
    assign b_hs_c  = bvalid_q & s_axi_control_bready;
    assign ar_hs_c = s_axi_control_arvalid & arready_q;
    assign r_hs_c  = rvalid_q & s_axi_control_rready;

    // State registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            w_state_q <= W_ADDR;
            r_state_q <= R_ADDR;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // Next-state logic for both channel FSMs
    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        case (w_state_q)
            W_ADDR:  if (aw_hs_c) w_state_d = W_DATA;
            W_DATA:  if (w_hs_c)  w_state_d = W_RESP;
            W_RESP:  if (b_hs_c)  w_state_d = W_ADDR;
            default: w_state_d = W_ADDR;
        endcase
        case (r_state_q)
            R_ADDR:  if (ar_hs_c) r_state_d = R_DATA;
            R_DATA:  if (r_hs_c)  r_state_d = R_ADDR;
            default: r_state_d = R_ADDR;
        endcase
    end

    // Channel handshake outputs follow the state being entered
    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        case (w_state_d)
            W_ADDR:  awready_d = 1'b1;
            W_DATA:  wready_d  = 1'b1;
            W_RESP:  bvalid_d  = 1'b1;
            default: awready_d = 1'b1;
        endcase
        case (r_state_d)
            R_ADDR:  arready_d = 1'b1;
            R_DATA:  rvalid_d  = 1'b1;
            default: arready_d = 1'b1;
        endcase
    end

    assign ctrl_status_c = DW'({~busy_q, done_q, busy_q});

    always_comb begin
        rdata_sel_c = '0;
        case (s_axi_control_araddr)
            ADDR_CTRL: rdata_sel_c = ctrl_status_c;
            ADDR_LEN:  rdata_sel_c = byte_len_q;
            ADDR_SRC:  rdata_sel_c = src_q;
            ADDR_DST:  rdata_sel_c = dst_q;
            default:   rdata_sel_c = '0;
        endcase
    end

    // A done pulse in the same cycle frees the engine for an incoming start
    assign start_acc_c = w_hs_c && (waddr_q == ADDR_CTRL) && s_axi_control_wdata[0]
                         && s_axi_control_wstrb[0] && !(busy_q && !ap_done);
    assign cfg_we_c    = w_hs_c && !busy_q;
    assign ctrl_rd_c   = ar_hs_c && (s_axi_control_araddr == ADDR_CTRL);

    always_comb begin
        waddr_d    = waddr_q;
        rdata_d    = rdata_q;
        ap_start_d = start_acc_c;
        busy_d     = busy_q;
        done_d     = done_q;
        byte_len_d = byte_len_q;
        src_d      = src_q;
        dst_d      = dst_q;
        if (aw_hs_c) waddr_d = s_axi_control_awaddr;
        if (ar_hs_c) rdata_d = rdata_sel_c;
        if (start_acc_c)  busy_d = 1'b1;
        else if (ap_done) busy_d = 1'b0;
        // Set wins over clear-on-read
        if (ap_done)        done_d = 1'b1;
        else if (ctrl_rd_c) done_d = 1'b0;
        if (cfg_we_c) begin
            case (waddr_q)
                ADDR_LEN: byte_len_d = merge_bytes(byte_len_q, s_axi_control_wdata, s_axi_control_wstrb);
                ADDR_SRC: src_d      = merge_bytes(src_q, s_axi_control_wdata, s_axi_control_wstrb);
                ADDR_DST: dst_d      = merge_bytes(dst_q, s_axi_control_wdata, s_axi_control_wstrb);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            waddr_q    <= '0;
            ap_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_len_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            waddr_q    <= waddr_d;
            ap_start_q <= ap_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_len_q <= byte_len_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
        end
    end

    assign s_axi_control_awready = awready_q;
    assign s_axi_control_wready  = wready_q;
    assign s_axi_control_bvalid  = bvalid_q;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = arready_q;
    assign s_axi_control_rvalid  = rvalid_q;
    assign s_axi_control_rdata   = rdata_q;
    assign s_axi_control_rresp   = 2'b00;
    assign ap_start              = ap_start_q;
    assign byte_len              = byte_len_q;
    assign src_addr              = src_q;
    assign dst_addr              = dst_q;

endmodule

// File: tb/tb_dmac_ctrl_slave.sv
// Directed bench for dmac_ctrl_slave; expected responses queued at issue, checked on rvalid/bvalid.
module tb_dmac_ctrl_slave;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        ap_start, ap_done;
    logic [31:0] byte_len, src_addr, dst_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] rq[$];
    logic [1:0]  bq[$];

    dmac_ctrl_slave dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .byte_len              (byte_len),
        .src_addr              (src_addr),
        .dst_addr              (dst_addr)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout", tag);
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit done_on_w, output logic start_seen, output logic start_after);
        int n;
        logic [1:0] exp_b;
        bq.push_back(2'b00);
        awvalid = 1'b1; awaddr = addr; n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        if (!awready) timeout("aw");
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = data; wstrb = strb; n = 0;
        while (!wready && n < 20) begin tick(); n++; end
        if (!wready) timeout("w");
        ap_done = done_on_w;
        tick();
        wvalid = 1'b0; ap_done = 1'b0;
        start_seen = ap_start;
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        exp_b = bq.pop_front();
        if (!bvalid) timeout("b");
        else check("bresp", 32'(bresp), 32'(exp_b));
        tick();
        start_after = ap_start;
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [11:0] addr, input logic [31:0] exp,
                            input bit done_on_ar, input int stall);
        int n;
        rq.push_back(exp);
        arvalid = 1'b1; araddr = addr; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (!arready) timeout({tag, "_ar"});
        ap_done = done_on_ar;
        tick();
        arvalid = 1'b0; ap_done = 1'b0; n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (!rvalid) begin
            timeout({tag, "_r"});
            void'(rq.pop_front());
        end else begin
            for (int i = 0; i < stall; i++) begin
                check({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
                check({tag, "_hold_rdata"}, rdata, rq[0]);
                tick();
            end
            rready = 1'b1;
            check(tag, rdata, rq.pop_front());
            check({tag, "_rresp"}, 32'(rresp), 32'd0);
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
    endtask

    initial begin
        logic s0, s1;
        ap_rst = 1'b1;
        awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
        arvalid = 0; araddr = '0; rready = 0; ap_done = 0;
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();

        // Reset state
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ap_start", 32'(ap_start), 32'd0);
        check("rst_byte_len", byte_len, 32'd0);
        check("rst_src", src_addr, 32'd0);
        check("rst_dst", dst_addr, 32'd0);
        axi_read("rd_ctrl_rst", 12'h010, 32'h4, 1'b0, 0);
        axi_read("rd_len_rst", 12'h014, 32'h0, 1'b0, 0);

        // Configuration registers
        axi_write(12'h014, 32'h0000_1000, 4'hF, 1'b0, s0, s1);
        axi_write(12'h018, 32'h1000_0000, 4'hF, 1'b0, s0, s1);
        axi_write(12'h01C, 32'h2000_0000, 4'hF, 1'b0, s0, s1);
        check("cfg_no_start", 32'(s0), 32'd0);
        check("byte_len", byte_len, 32'h0000_1000);
        check("src_addr", src_addr, 32'h1000_0000);
        check("dst_addr", dst_addr, 32'h2000_0000);
        axi_read("rd_len", 12'h014, 32'h0000_1000, 1'b0, 0);
        axi_read("rd_src", 12'h018, 32'h1000_0000, 1'b0, 0);
        axi_read("rd_dst", 12'h01C, 32'h2000_0000, 1'b0, 0);

        // Start, ignored restart and config writes while busy
        axi_write(12'h010, 32'h1, 4'hF, 1'b0, s0, s1);
        check("start_pulse", 32'(s0), 32'd1);
        check("start_one_cycle", 32'(s1), 32'd0);
        axi_read("rd_ctrl_busy", 12'h010, 32'h1, 1'b0, 0);
        axi_write(12'h010, 32'h1, 4'hF, 1'b0, s0, s1);
        check("restart_busy_no_pulse", 32'(s0), 32'd0);
        axi_write(12'h014, 32'h20, 4'hF, 1'b0, s0, s1);
        check("len_busy_ignored", byte_len, 32'h0000_1000);

        // Done sticky, clear on read
        pulse_done();
        axi_read("rd_ctrl_done", 12'h010, 32'h6, 1'b0, 0);
        axi_read("rd_ctrl_cleared", 12'h010, 32'h4, 1'b0, 0);

        // Done coincident with CTRL read address handshake
        axi_write(12'h010, 32'h1, 4'hF, 1'b0, s0, s1);
        check("start2_pulse", 32'(s0), 32'd1);
        axi_read("rd_ctrl_coinc", 12'h010, 32'h1, 1'b1, 0);
        axi_read("rd_ctrl_after_coinc", 12'h010, 32'h6, 1'b0, 0);
        axi_read("rd_ctrl_after_clear", 12'h010, 32'h4, 1'b0, 0);

        // Done coincident with a start write handshake
        axi_write(12'h010, 32'h1, 4'hF, 1'b0, s0, s1);
        axi_write(12'h010, 32'h1, 4'hF, 1'b1, s0, s1);
        check("start_with_done_pulse", 32'(s0), 32'd1);
        check("start_with_done_one", 32'(s1), 32'd0);
        axi_read("rd_ctrl_busy_done", 12'h010, 32'h3, 1'b0, 0);
        axi_read("rd_ctrl_busy_only", 12'h010, 32'h1, 1'b0, 0);
        pulse_done();
        axi_read("rd_ctrl_done2", 12'h010, 32'h6, 1'b0, 0);
        axi_read("rd_ctrl_idle2", 12'h010, 32'h4, 1'b0, 0);

        // Byte strobes and masked start
        axi_write(12'h018, 32'hAABB_CCDD, 4'b0010, 1'b0, s0, s1);
        check("src_strobe", src_addr, 32'h1000_CC00);
        axi_write(12'h010, 32'h1, 4'b1110, 1'b0, s0, s1);
        check("start_strb0_low", 32'(s0), 32'd0);
        axi_read("rd_ctrl_no_start", 12'h010, 32'h4, 1'b0, 0);

        // Unmapped address
        axi_write(12'h020, 32'hDEAD_BEEF, 4'hF, 1'b0, s0, s1);
        check("unmapped_len", byte_len, 32'h0000_1000);
        check("unmapped_dst", dst_addr, 32'h2000_0000);
        axi_read("rd_unmapped", 12'h020, 32'h0, 1'b0, 0);

        // Read data held while rready low
        axi_read("rd_dst_stall", 12'h01C, 32'h2000_0000, 1'b0, 5);

        // Reset asserted during W_DATA
        awvalid = 1'b1; awaddr = 12'h014;
        tick();
        awvalid = 1'b0;
        check("pre_rst_wready", 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; bready = 1'b1;
        ap_rst = 1'b1;
        #1;
        check("mid_rst_awready", 32'(awready), 32'd1);
        check("mid_rst_wready", 32'(wready), 32'd0);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_len", byte_len, 32'd0);
        check("mid_rst_src", src_addr, 32'd0);
        tick();
        wvalid = 1'b0; ap_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_bvalid", 32'(bvalid), 32'd0);
        end
        bready = 1'b0;
        axi_read("rd_ctrl_post_rst", 12'h010, 32'h4, 1'b0, 0);
        axi_read("rd_len_post_rst", 12'h014, 32'h0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
